avl_vlb_ram_slave: RTL and testbench



---
 rtl/avl_vlb_pkg.sv | 18 +
 rtl/avl_vlb_sdp_ram.sv | 40 ++++
 rtl/avl_vlb_ram_slave.sv | 163 ++++++++++++++++
 tb/tb_avl_vlb_ram_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_vlb_pkg.sv
// Shared types and helpers for the variable-length-burst RAM slave.
package avl_vlb_pkg;

    // Widest burstcount the normalisation helper accepts.
    localparam int unsigned BCNT_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // A burstcount of zero behaves as a single-word burst.
    function automatic logic [BCNT_MAX_W-1:0] norm_bcnt(input logic [BCNT_MAX_W-1:0] bcnt);
        return (bcnt == '0) ? BCNT_MAX_W'(1) : bcnt;
    endfunction

endpackage

// File: rtl/avl_vlb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module avl_vlb_sdp_ram #(
    parameter int unsigned DWIDTH  = 64,
    parameter int unsigned AWIDTH  = 6,
    parameter string       RAMTYPE = "AUTO"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    (* ram_style = RAMTYPE *) logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/avl_vlb_ram_slave.sv
// Avalon-MM variable-length-burst slave backed by on-chip RAM.
module avl_vlb_ram_slave
    import avl_vlb_pkg::*;
#(
    parameter int unsigned DWIDTH    = 64,
    parameter int unsigned AWIDTH    = 6,
    parameter int unsigned BWIDTH    = 4,
    parameter int unsigned RDLATENCY = 2,
    parameter string       RAMTYPE   = "AUTO"
) (
    input  logic              reset,
    input  logic              clk,
    input  logic [AWIDTH-1:0] avs_address,
    input  logic [BWIDTH-1:0] avs_burstcount,
    input  logic              avs_write,
    input  logic [DWIDTH-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DWIDTH-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [BWIDTH-1:0] cnt_q, cnt_d;
    logic              wait_q;
    logic [BWIDTH-1:0] bcnt_c;
    logic              ram_we_c, ram_re_c;
    logic [AWIDTH-1:0] ram_waddr_c, ram_raddr_c;
    logic [DWIDTH-1:0] ram_rdata;
    logic [RDLATENCY-1:0] vld_q;

    assign bcnt_c          = BWIDTH'(norm_bcnt(BCNT_MAX_W'(avs_burstcount)));
    assign avs_waitrequest = wait_q;

    // State, burst address/count and the registered stall flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wait_q  <= (state_d == READ);
        end
    end

    // Next-state decode; a write beats a simultaneous read in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!wait_q) begin
                    if (avs_write) begin
                        if (bcnt_c > BWIDTH'(1)) state_d = WRITE;
                    end else if (avs_read && (bcnt_c > BWIDTH'(1))) begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (avs_write && (cnt_q == BWIDTH'(1))) state_d = IDLE;
            end
            READ: begin
                if (cnt_q == BWIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port controls and burst address/count updates per state.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
        ram_waddr_c = addr_q;
        ram_raddr_c = addr_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (!wait_q && (avs_write || avs_read)) begin
                    addr_d = avs_address + AWIDTH'(1);
                    cnt_d  = bcnt_c - BWIDTH'(1);
                    if (avs_write) begin
                        ram_we_c    = 1'b1;
                        ram_waddr_c = avs_address;
                    end else begin
                        ram_re_c    = 1'b1;
                        ram_raddr_c = avs_address;
                    end
                end
            end
            WRITE: begin
                if (avs_write) begin
                    ram_we_c = 1'b1;
                    addr_d   = addr_q + AWIDTH'(1);
                    cnt_d    = cnt_q - BWIDTH'(1);
                end
            end
            READ: begin
                ram_re_c = 1'b1;
                addr_d   = addr_q + AWIDTH'(1);
                cnt_d    = cnt_q - BWIDTH'(1);
            end
            default: ;
        endcase
    end

    avl_vlb_sdp_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .RAMTYPE(RAMTYPE)
    ) u_ram (
        .clk    (clk),
        .rst_n  (reset),
        .we_i   (ram_we_c),
        .waddr_i(ram_waddr_c),
        .wdata_i(avs_writedata),
        .re_i   (ram_re_c),
        .raddr_i(ram_raddr_c),
        .rdata_o(ram_rdata)
    );

    // Valid flags shadow the data through the read latency pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= ram_re_c;
            for (int i = 1; i < RDLATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign avs_readdatavalid = vld_q[RDLATENCY-1];

    if (RDLATENCY > 1) begin : g_pipe
        logic [DWIDTH-1:0] data_q [RDLATENCY-1];

        // Data stages load only with a valid word so the output holds otherwise.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < RDLATENCY - 1; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                if (vld_q[0]) data_q[0] <= ram_rdata;
                for (int i = 1; i < RDLATENCY - 1; i++) begin
                    if (vld_q[i]) data_q[i] <= data_q[i-1];
                end
            end
        end

        assign avs_readdata = data_q[RDLATENCY-2];
    end else begin : g_direct
        assign avs_readdata = ram_rdata;
    end

endmodule

// File: tb/tb_avl_vlb_ram_slave.sv
// Directed bench for avl_vlb_ram_slave; a latency-2 and a latency-5 instance share stimulus.
module tb_avl_vlb_ram_slave;

    logic        clk;
    logic        reset;
    logic [5:0]  avs_address;
    logic [3:0]  avs_burstcount;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic        avs_read;
    logic [63:0] rdata2, rdata5;
    logic        rvalid2, rvalid5;
    logic        avs_waitrequest, wait5;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          c;
        logic [63:0] d;
    } cap_t;

    typedef struct {
        logic [5:0]       addr;
        logic [3:0]       bcnt;
        int               n;
        int               gap;
        logic [7:0][63:0] data;
    } wvec_t;

    typedef struct {
        logic [5:0]       addr;
        logic [3:0]       bcnt;
        int               n;
        logic [7:0][63:0] exp;
    } rvec_t;

    cap_t  q2[$];
    cap_t  q5[$];
    wvec_t wv[2];
    rvec_t rv[6];

    avl_vlb_ram_slave #(.DWIDTH(64), .AWIDTH(6), .BWIDTH(4), .RDLATENCY(2), .RAMTYPE("AUTO")) dut2 (
        .reset(reset), .clk(clk),
        .avs_address(avs_address), .avs_burstcount(avs_burstcount),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(rdata2), .avs_readdatavalid(rvalid2), .avs_waitrequest(avs_waitrequest)
    );

    avl_vlb_ram_slave #(.DWIDTH(64), .AWIDTH(6), .BWIDTH(4), .RDLATENCY(5), .RAMTYPE("AUTO")) dut5 (
        .reset(reset), .clk(clk),
        .avs_address(avs_address), .avs_burstcount(avs_burstcount),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
        .avs_readdata(rdata5), .avs_readdatavalid(rvalid5), .avs_waitrequest(wait5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid word with the cycle it appeared in.
    always @(negedge clk) begin
        cap_t e;
        if (rvalid2) begin
            e.c = cyc; e.d = rdata2; q2.push_back(e);
        end
        if (rvalid5) begin
            e.c = cyc; e.d = rdata5; q5.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (avs_waitrequest && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            nvec++;
            nerr++;
            $display("FAIL wait_ready: waitrequest still 1 after %0d cycles, expected 0", k);
        end
    endtask

    task automatic issue_read(input logic [5:0] addr, input logic [3:0] bcnt, output int t);
        wait_ready();
        avs_address    = addr;
        avs_burstcount = bcnt;
        avs_read       = 1'b1;
        t              = cyc;
        tick();
        avs_read       = 1'b0;
    endtask

    task automatic wr_burst(input wvec_t w);
        wait_ready();
        for (int i = 0; i < w.n; i++) begin
            avs_write     = 1'b1;
            avs_writedata = w.data[i];
            if (i == 0) begin
                avs_address    = w.addr;
                avs_burstcount = w.bcnt;
            end else begin
                avs_address    = 6'(i * 7 + 33);
                avs_burstcount = 4'hF;
            end
            tick();
            if (i == w.gap) begin
                avs_write     = 1'b0;
                avs_writedata = '1;
                check("wr gap wait", 64'(avs_waitrequest), 64'd0);
                tick();
            end
        end
        avs_write = 1'b0;
    endtask

    task automatic run_read(input rvec_t v, input string tag);
        int t;
        q2.delete();
        q5.delete();
        issue_read(v.addr, v.bcnt, t);
        for (int i = 1; i < v.n; i++) begin
            check({tag, " wait_hi"}, 64'(avs_waitrequest), 64'd1);
            tick();
        end
        check({tag, " wait_lo"}, 64'(avs_waitrequest), 64'd0);
        repeat (10) tick();
        check({tag, " count L2"}, 64'(q2.size()), 64'(v.n));
        check({tag, " count L5"}, 64'(q5.size()), 64'(v.n));
        for (int i = 0; i < v.n && i < q2.size(); i++) begin
            check({tag, " data L2"}, q2[i].d, v.exp[i]);
            check({tag, " cycle L2"}, 64'(q2[i].c), 64'(t + 2 + i));
        end
        for (int i = 0; i < v.n && i < q5.size(); i++) begin
            check({tag, " data L5"}, q5[i].d, v.exp[i]);
            check({tag, " cycle L5"}, 64'(q5[i].c), 64'(t + 5 + i));
        end
    endtask

    initial begin
        int          t, t2;
        logic [63:0] b2b_exp [5];
        logic [63:0] a0, a1, a2, a3;

        a0 = 64'hDEAD_BEEF_0000_00A0;
        a1 = 64'hDEAD_BEEF_0000_00A1;
        a2 = 64'hDEAD_BEEF_0000_00A2;
        a3 = 64'hDEAD_BEEF_0000_00A3;

        wv[0].addr = 6'd5;  wv[0].bcnt = 4'd4; wv[0].n = 4; wv[0].gap = 1;
        wv[0].data = '0;
        wv[0].data[0] = a0; wv[0].data[1] = a1; wv[0].data[2] = a2; wv[0].data[3] = a3;
        wv[1].addr = 6'd62; wv[1].bcnt = 4'd4; wv[1].n = 4; wv[1].gap = -1;
        wv[1].data = '0;
        wv[1].data[0] = 64'd1; wv[1].data[1] = 64'd2; wv[1].data[2] = 64'd3; wv[1].data[3] = 64'd4;

        for (int i = 0; i < 6; i++) rv[i].exp = '0;
        rv[0].addr = 6'd5;  rv[0].bcnt = 4'd4; rv[0].n = 4;
        rv[0].exp[0] = a0; rv[0].exp[1] = a1; rv[0].exp[2] = a2; rv[0].exp[3] = a3;
        rv[1].addr = 6'd0;  rv[1].bcnt = 4'd2; rv[1].n = 2;
        rv[1].exp[0] = 64'd3; rv[1].exp[1] = 64'd4;
        rv[2].addr = 6'd62; rv[2].bcnt = 4'd1; rv[2].n = 1;
        rv[2].exp[0] = 64'd1;
        rv[3].addr = 6'd63; rv[3].bcnt = 4'd0; rv[3].n = 1;
        rv[3].exp[0] = 64'd2;
        rv[4].addr = 6'd6;  rv[4].bcnt = 4'd2; rv[4].n = 2;
        rv[4].exp[0] = a1; rv[4].exp[1] = a2;
        rv[5].addr = 6'd62; rv[5].bcnt = 4'd3; rv[5].n = 3;
        rv[5].exp[0] = 64'd1; rv[5].exp[1] = 64'd2; rv[5].exp[2] = 64'd3;

        b2b_exp[0] = a0; b2b_exp[1] = a1; b2b_exp[2] = a2;
        b2b_exp[3] = 64'd1; b2b_exp[4] = 64'd2;

        // Reset values.
        reset          = 1'b0;
        avs_address    = '0;
        avs_burstcount = '0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_read       = 1'b0;
        repeat (3) tick();
        check("reset valid L2", 64'(rvalid2), 64'd0);
        check("reset valid L5", 64'(rvalid5), 64'd0);
        check("reset data", rdata2, 64'd0);
        check("reset wait", 64'(avs_waitrequest), 64'd1);
        reset = 1'b1;
        tick();
        check("post-reset wait", 64'(avs_waitrequest), 64'd0);

        // Write bursts, one with an idle gap, one wrapping past the top address.
        for (int i = 0; i < 2; i++) wr_burst(wv[i]);

        // Read vectors.
        for (int i = 0; i < 6; i++) run_read(rv[i], $sformatf("rd%0d", i));

        // Back-to-back reads: second command accepted as soon as the first drains.
        q2.delete();
        q5.delete();
        issue_read(6'd5, 4'd3, t);
        issue_read(6'd62, 4'd2, t2);
        check("b2b accept", 64'(t2), 64'(t + 3));
        repeat (10) tick();
        check("b2b count", 64'(q2.size()), 64'd5);
        for (int i = 0; i < 5 && i < q2.size(); i++) begin
            check("b2b data", q2[i].d, b2b_exp[i]);
            check("b2b cycle", 64'(q2[i].c), 64'(t + 2 + i));
        end

        // Simultaneous read and write in IDLE: write wins, read follows with new data.
        q2.delete();
        q5.delete();
        wait_ready();
        avs_address    = 6'd10;
        avs_burstcount = 4'd2;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        avs_writedata  = 64'h0000_0000_0000_00B0;
        t              = cyc;
        tick();
        check("sim wait in write", 64'(avs_waitrequest), 64'd0);
        avs_writedata = 64'h0000_0000_0000_00B1;
        tick();
        avs_write = 1'b0;
        check("sim wait idle", 64'(avs_waitrequest), 64'd0);
        tick();
        avs_read = 1'b0;
        check("sim wait in read", 64'(avs_waitrequest), 64'd1);
        repeat (10) tick();
        check("sim count L2", 64'(q2.size()), 64'd2);
        check("sim count L5", 64'(q5.size()), 64'd2);
        for (int i = 0; i < 2 && i < q2.size(); i++) begin
            check("sim data", q2[i].d, 64'(64'hB0 + i));
            check("sim cycle L2", 64'(q2[i].c), 64'(t + 4 + i));
        end
        if (q5.size() > 0) check("sim cycle L5", 64'(q5[0].c), 64'(t + 7));

        // Reset in the middle of a long read burst.
        issue_read(6'd5, 4'd8, t);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst valid L2", 64'(rvalid2), 64'd0);
        check("midrst valid L5", 64'(rvalid5), 64'd0);
        check("midrst wait", 64'(avs_waitrequest), 64'd1);
        check("midrst data", rdata2, 64'd0);
        tick();
        reset = 1'b1;
        q2.delete();
        q5.delete();
        tick();
        check("midrst wait after", 64'(avs_waitrequest), 64'd0);
        repeat (12) tick();
        check("midrst flush L2", 64'(q2.size()), 64'd0);
        check("midrst flush L5", 64'(q5.size()), 64'd0);
        run_read(rv[0], "reread");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
